memory_responder: RTL and testbench
===================================

# memory_responder

Word-addressed memory slave on the far side of the datapath's MAR/MDR interface. It accepts read and write requests using the address from MAR and the write data from MDR. After a configurable number of wait states, it returns read data on `Mdatain` and pulses a ready handshake. This stands in for main memory in datapath and control-unit benches, and is the target that the MDR `Read` path fetches from.

## Interface
Parameters:
- `MEM_WORDS`, 512: number of 32-bit words. Must be a power of two, minimum 2.
- `WAIT_CYCLES`, 2: wait states inserted before a response. Legal range 0–15.

Ports:
- `clock`  in  1: single clock. All state updates on the rising edge.
- `clear`  in  1: **asynchronous, active-low reset.**
- `MARaddr`  in  32: word address driven by MAR.
- `MDRdata`  in  32: write data driven by MDR.
- `Read`  in  1: read request (level).
- `Write`  in  1: write request (level).
- `Mdatain`  out  32: read data to MDR.
- `MemReady`  out  1: one-cycle completion pulse.
- `Busy`  out  1: high while a request is in flight (WAIT, RESP).
- `Err`  out  1: one-cycle error pulse, aligned with `MemReady`.

## Operation
- States:
  - IDLE: waiting for a request.
  - WAIT: counting wait states.
  - RESP: completing the request.
  - HOLD: waiting for the requester to release.
- **IDLE**
  - On `Read` xor `Write` high: capture the address, the data and the op; go to WAIT with `cnt=WAIT_CYCLES-1`.
  - If `WAIT_CYCLES=0`, go directly to RESP.
  - On `Read` and `Write` both high: no access occurs. Go to RESP flagged as an illegal op, which pulses `Err` with `MemReady`; `Mdatain` is unchanged.
- **WAIT**
  - Decrement `cnt` each edge.
  - When `cnt==0`, go to RESP on that edge.
  - Input changes are ignored; captured values are used throughout.
- **On the edge entering RESP**
  - Read: `Mdatain <= mem[idx]`.
  - Write: `mem[idx] <= captured data`; `Mdatain` is unchanged.
  - `MemReady <= 1`.
- **RESP**
  - Lasts exactly one cycle, then goes to HOLD.
  - `MemReady` and `Err` return to 0.
- **HOLD**
  - Stay until `Read` and `Write` are both low, then go to IDLE.
  - This guarantees a level-held request is serviced exactly once.
- **Address mapping:** `idx = MARaddr[log2(MEM_WORDS)-1:0]`.
- **`Mdatain` retention:** holds the last read value until the next successful read completes.
- **Reset values:**
  - `Mdatain=0`, `MemReady=0`, `Busy=0`, `Err=0`.
  - State is IDLE and `cnt=0`.
  - Memory array contents are not reset.
- **Reset mid-operation:**
  - Returns to IDLE immediately.
  - A pending write is dropped and the array is untouched.
  - After `clear` deasserts, a still-asserted request is treated as new.

## Timing
- **Latency:** request sampled at edge E0; `MemReady` high for the cycle after edge E0+`WAIT_CYCLES`. With the default of 2, that is the third cycle after the request is presented.
- **Data validity:** `Mdatain` is valid from the cycle `MemReady` rises. The requester latches it into MDR with `Read`/`MDRin` during or after that cycle.
- **Write visibility:** a write is visible to a read accepted on any later edge.
- **Busy:** rises after E0 and falls on the edge leaving RESP. It is low in HOLD and IDLE.
- **Throughput:** minimum back-to-back spacing is `WAIT_CYCLES` + 3 cycles, because the request must drop for one cycle in HOLD.
- **Outputs:** all outputs are registered; there are no combinational paths from input to output.

## Configuration
- **`MEMRESP_BOUNDS_CHECK_EN` defined:**
  - A request with `MARaddr >= MEM_WORDS` is out of range. It completes with normal latency and `Err` pulses with `MemReady`.
  - Out-of-range reads load `Mdatain=0`.
  - Out-of-range writes are discarded.
- **Not defined:** addresses wrap modulo `MEM_WORDS` using the low bits, and `Err` fires only for a simultaneous `Read`/`Write`.

## Test plan
- Reset with `clear=0` mid-WAIT of a write to address 5 (`0xDEADBEEF`), then release and read 5 → the prior contents are returned, and `MemReady` pulses 3 cycles after `Read` is asserted.
- Write `0x12345678` to address 10, drop the request, then read 10 → `Mdatain=0x12345678` with `MemReady` high for exactly 1 cycle. `Busy` is high for 3 cycles.
- Hold `Read` high for 10 cycles at address 3 → exactly one `MemReady` pulse; a second pulse occurs only after `Read` drops and rises again.
- Assert `Read=1` and `Write=1` together → `Err` and `MemReady` pulse together, `Mdatain` is unchanged, and memory is unchanged.
- With `WAIT_CYCLES=0`, read address 7 → `MemReady` is high in the cycle after the request edge.
- With `MEMRESP_BOUNDS_CHECK_EN` and `MEM_WORDS=512`, write `0xAA` to 512 → `Err` pulses and address 0 is unchanged. Without the macro, the same write lands at address 0.

Source files
------------

// File: rtl/memory_responder_if.sv
// Requester-side bus of memory_responder: MAR/MDR request signals toward the
// memory and read data, completion and error handshake back to the MDR.
interface memory_responder_if;
    logic [31:0] MARaddr;
    logic [31:0] MDRdata;
    logic        Read;
    logic        Write;
    logic [31:0] Mdatain;
    logic        MemReady;
    logic        Busy;
    logic        Err;

    modport master (
        output MARaddr, MDRdata, Read, Write,
        input  Mdatain, MemReady, Busy, Err
    );

    modport slave (
        input  MARaddr, MDRdata, Read, Write,
        output Mdatain, MemReady, Busy, Err
    );
endinterface

// File: rtl/memory_responder.sv
// Word-addressed memory slave with WAIT_CYCLES wait states and a one-shot ready pulse.
// Optional MEMRESP_BOUNDS_CHECK_EN: out-of-range addresses raise Err instead of wrapping.
module memory_responder #(
    parameter int unsigned MEM_WORDS   = 512,
    parameter int unsigned WAIT_CYCLES = 2
) (
    input  logic              clock,
    input  logic              clear,
    memory_responder_if.slave bus
);
    localparam int unsigned AW = $clog2(MEM_WORDS);

`ifdef MEMRESP_BOUNDS_CHECK_EN
    localparam bit BOUNDS_CHECK = 1'b1;
`else
    localparam bit BOUNDS_CHECK = 1'b0;
`endif

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP, S_HOLD} state_t;

    state_t          r_state;
    logic [3:0]      r_cnt;
    logic            r_is_wr;
    logic            r_oob;
    logic [AW-1:0]   r_idx;
    logic [31:0]     r_data;
    logic [31:0]     r_mdatain;
    logic            r_ready;
    logic            r_busy;
    logic            r_err;
    logic [31:0]     r_mem [MEM_WORDS];

    logic            w_single;
    logic            w_in_oob;
    logic            w_direct;
    logic            w_enter_resp;
    logic            w_acc_wr;
    logic            w_acc_oob;
    logic [AW-1:0]   w_acc_idx;
    logic [31:0]     w_acc_data;
    logic            w_mem_we;

    assign w_single = bus.Read ^ bus.Write;
    assign w_in_oob = BOUNDS_CHECK && (bus.MARaddr[31:AW] != '0);

    // With no wait states the access completes on the acceptance edge, so it
    // must use the live inputs rather than the (not yet loaded) capture regs.
    assign w_direct     = (WAIT_CYCLES == 0) && (r_state == S_IDLE) && w_single;
    assign w_enter_resp = w_direct || ((r_state == S_WAIT) && (r_cnt == '0));
    assign w_acc_wr     = w_direct ? bus.Write           : r_is_wr;
    assign w_acc_oob    = w_direct ? w_in_oob            : r_oob;
    assign w_acc_idx    = w_direct ? bus.MARaddr[AW-1:0] : r_idx;
    assign w_acc_data   = w_direct ? bus.MDRdata         : r_data;
    assign w_mem_we     = w_enter_resp && w_acc_wr && !w_acc_oob;

    always_ff @(posedge clock) begin
        if (w_mem_we) begin
            r_mem[w_acc_idx] <= w_acc_data;
        end
    end

    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_is_wr   <= 1'b0;
            r_oob     <= 1'b0;
            r_idx     <= '0;
            r_data    <= '0;
            r_mdatain <= '0;
            r_ready   <= 1'b0;
            r_busy    <= 1'b0;
            r_err     <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.Read && bus.Write) begin
                        r_state <= S_RESP;
                        r_ready <= 1'b1;
                        r_err   <= 1'b1;
                        r_busy  <= 1'b1;
                    end else if (w_single) begin
                        r_is_wr <= bus.Write;
                        r_oob   <= w_in_oob;
                        r_idx   <= bus.MARaddr[AW-1:0];
                        r_data  <= bus.MDRdata;
                        r_busy  <= 1'b1;
                        if (WAIT_CYCLES == 0) begin
                            r_state <= S_RESP;
                        end else begin
                            r_state <= S_WAIT;
                            r_cnt   <= 4'(WAIT_CYCLES - 1);
                        end
                    end
                end
                S_WAIT: begin
                    if (r_cnt == '0) begin
                        r_state <= S_RESP;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                S_RESP: begin
                    r_state <= S_HOLD;
                    r_ready <= 1'b0;
                    r_err   <= 1'b0;
                    r_busy  <= 1'b0;
                end
                S_HOLD: begin
                    if (!bus.Read && !bus.Write) begin
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase

            if (w_enter_resp) begin
                r_ready <= 1'b1;
                r_err   <= w_acc_oob;
                if (!w_acc_wr) begin
                    r_mdatain <= w_acc_oob ? '0 : r_mem[w_acc_idx];
                end
            end
        end
    end

    assign bus.Mdatain  = r_mdatain;
    assign bus.MemReady = r_ready;
    assign bus.Busy     = r_busy;
    assign bus.Err      = r_err;
endmodule

// File: tb/tb_memory_responder.sv
// Scoreboard bench for memory_responder: a zero-wait 16-word instance and a default
// instance share one request bus and are checked against a per-instance memory model.
module tb_memory_responder;
    localparam int unsigned FW_WORDS = 16;
    localparam int unsigned FW_WAIT  = 0;
    localparam int unsigned DW_WORDS = 512;
    localparam int unsigned DW_WAIT  = 2;

`ifdef MEMRESP_BOUNDS_CHECK_EN
    localparam bit BCHK = 1'b1;
`else
    localparam bit BCHK = 1'b0;
`endif

    typedef struct {
        logic [31:0] data;
        logic        err;
        int unsigned cyc;
        int unsigned busy;
    } exp_t;

    logic        clock;
    logic        clear;
    logic        Read;
    logic        Write;
    logic [31:0] MARaddr;
    logic [31:0] MDRdata;

    int unsigned cyc;
    int unsigned checks;
    int unsigned errors;
    int unsigned busy_run [2];
    int unsigned exp_busy [2];
    logic [31:0] mdl_mem  [2][DW_WORDS];
    logic [31:0] mdl_last [2];
    exp_t        qf [$];
    exp_t        qd [$];

    memory_responder_if bf ();
    memory_responder_if bd ();

    assign bf.MARaddr = MARaddr;
    assign bf.MDRdata = MDRdata;
    assign bf.Read    = Read;
    assign bf.Write   = Write;
    assign bd.MARaddr = MARaddr;
    assign bd.MDRdata = MDRdata;
    assign bd.Read    = Read;
    assign bd.Write   = Write;

    memory_responder #(.MEM_WORDS(FW_WORDS), .WAIT_CYCLES(FW_WAIT)) u_fast (
        .clock(clock),
        .clear(clear),
        .bus  (bf)
    );

    memory_responder #(.MEM_WORDS(DW_WORDS), .WAIT_CYCLES(DW_WAIT)) u_dflt (
        .clock(clock),
        .clear(clear),
        .bus  (bd)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    initial begin
        #2000000;
        $display("FAIL watchdog cyc=%0d got=still running want=finished", cyc);
        $fatal(1, "watchdog expired");
    end

    // Reference: one request -> expected response of instance d (0 fast, 1 default)
    function automatic exp_t model_step(input int d, input bit rd, input bit wr,
                                        input logic [31:0] addr, input logic [31:0] data,
                                        input int unsigned now);
        exp_t        e;
        int unsigned words;
        int unsigned wc;
        int unsigned idx;
        bit          oob;
        words = (d == 0) ? FW_WORDS : DW_WORDS;
        wc    = (d == 0) ? FW_WAIT  : DW_WAIT;
        idx   = addr % words;
        oob   = BCHK && (addr >= words);
        if (rd && wr) begin
            e.err  = 1'b1;
            e.cyc  = now + 1;
            e.busy = 1;
        end else begin
            e.err  = oob;
            e.cyc  = now + 1 + wc;
            e.busy = wc + 1;
            if (rd) mdl_last[d] = oob ? 32'h0 : mdl_mem[d][idx];
            else if (!oob) mdl_mem[d][idx] = data;
        end
        e.data = mdl_last[d];
        return e;
    endfunction

    task automatic check(input int d, input string name, input logic [31:0] act, input logic [31:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s dut%0d cyc=%0d got=%h want=%h", name, d, cyc, act, want);
        end
    endtask

    task automatic mon_sample(input int d, input logic rdy, input logic err,
                              input logic busy, input logic [31:0] dat);
        exp_t e;
        if (err) check(d, "err_needs_ready", {31'b0, rdy}, 32'd1);
        if (rdy) begin
            if ((d == 0 && qf.size() == 0) || (d != 0 && qd.size() == 0)) begin
                checks++;
                errors++;
                $display("FAIL unexpected_ready dut%0d cyc=%0d got=ready want=no ready", d, cyc);
            end else begin
                if (d == 0) e = qf.pop_front();
                else        e = qd.pop_front();
                check(d, "ready_cycle", cyc, e.cyc);
                check(d, "err", {31'b0, err}, {31'b0, e.err});
                check(d, "mdatain", dat, e.data);
                exp_busy[d] = e.busy;
            end
        end
        if (busy) begin
            busy_run[d]++;
        end else if (busy_run[d] != 0) begin
            check(d, "busy_cycles", busy_run[d], exp_busy[d]);
            busy_run[d] = 0;
        end
    endtask

    always @(negedge clock) begin
        if (clear) begin
            mon_sample(0, bf.MemReady, bf.Err, bf.Busy, bf.Mdatain);
            mon_sample(1, bd.MemReady, bd.Err, bd.Busy, bd.Mdatain);
        end else begin
            busy_run[0] = 0;
            busy_run[1] = 0;
        end
    end

    task automatic check_reset();
        check(0, "rst_mdatain",  bf.Mdatain, 32'h0);
        check(0, "rst_memready", {31'b0, bf.MemReady}, 32'h0);
        check(0, "rst_busy",     {31'b0, bf.Busy}, 32'h0);
        check(0, "rst_err",      {31'b0, bf.Err}, 32'h0);
        check(1, "rst_mdatain",  bd.Mdatain, 32'h0);
        check(1, "rst_memready", {31'b0, bd.MemReady}, 32'h0);
        check(1, "rst_busy",     {31'b0, bd.Busy}, 32'h0);
        check(1, "rst_err",      {31'b0, bd.Err}, 32'h0);
    endtask

    // Entered and left at negedge+1; holds the request 'hold' cycles past E0.
    task automatic do_req(input bit rd, input bit wr, input logic [31:0] addr,
                          input logic [31:0] data, input int unsigned hold);
        exp_t        e;
        int unsigned n;
        e = model_step(0, rd, wr, addr, data, cyc);
        qf.push_back(e);
        e = model_step(1, rd, wr, addr, data, cyc);
        qd.push_back(e);
        MARaddr = addr;
        MDRdata = data;
        Read    = rd;
        Write   = wr;
        repeat (hold) begin
            @(negedge clock);
            #1;
            MARaddr = $urandom;
            MDRdata = $urandom;
        end
        n = 0;
        while ((qf.size() != 0 || qd.size() != 0) && n < 40) begin
            @(negedge clock);
            #1;
            n++;
        end
        if (qf.size() != 0 || qd.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL response_timeout cyc=%0d got=pending %0d/%0d want=0/0", cyc, qf.size(), qd.size());
            qf.delete();
            qd.delete();
        end
        Read  = 1'b0;
        Write = 1'b0;
        repeat ($urandom_range(2, 4)) @(negedge clock);
        #1;
    endtask

    // Write to 5 completes at once on the fast instance but is cut off mid-WAIT on the default one.
    task automatic reset_mid_write();
        exp_t e;
        e = model_step(0, 1'b0, 1'b1, 32'd5, 32'hDEADBEEF, cyc);
        qf.push_back(e);
        MARaddr = 32'd5;
        MDRdata = 32'hDEADBEEF;
        Read    = 1'b0;
        Write   = 1'b1;
        @(negedge clock);
        #1;
        clear = 1'b0;
        Write = 1'b0;
        @(negedge clock);
        #1;
        check_reset();
        check(0, "fast_write_completed", qf.size(), 32'd0);
        qf.delete();
        mdl_last[0] = 32'h0;
        mdl_last[1] = 32'h0;
        clear = 1'b1;
        repeat (2) @(negedge clock);
        #1;
    endtask

    initial begin
        clear       = 1'b0;
        Read        = 1'b0;
        Write       = 1'b0;
        MARaddr     = '0;
        MDRdata     = '0;
        checks      = 0;
        errors      = 0;
        busy_run[0] = 0;
        busy_run[1] = 0;
        exp_busy[0] = 0;
        exp_busy[1] = 0;
        mdl_last[0] = 32'h0;
        mdl_last[1] = 32'h0;
        repeat (3) @(negedge clock);
        #1;
        check_reset();
        clear = 1'b1;
        repeat (2) @(negedge clock);
        #1;

        for (int a = 0; a < int'(DW_WORDS); a++) do_req(1'b0, 1'b1, 32'(a), $urandom, 0);

        reset_mid_write();
        do_req(1'b1, 1'b0, 32'd5, $urandom, 0);

        do_req(1'b0, 1'b1, 32'd10, 32'h12345678, 1);
        do_req(1'b1, 1'b0, 32'd10, 32'h0, 2);

        do_req(1'b1, 1'b0, 32'd3, 32'h0, 10);
        do_req(1'b1, 1'b0, 32'd3, 32'h0, 0);

        do_req(1'b1, 1'b1, 32'd7, 32'h55, 1);
        do_req(1'b1, 1'b0, 32'd7, 32'h0, 0);

        do_req(1'b0, 1'b1, 32'd512, 32'hAA, 0);
        do_req(1'b1, 1'b0, 32'd0, 32'h0, 0);

        for (int i = 0; i < 300; i++) begin
            int unsigned r;
            bit          rd;
            bit          wr;
            logic [31:0] addr;
            r  = $urandom_range(0, 9);
            rd = (r <= 4) || (r == 9);
            wr = (r >= 5);
            if ($urandom_range(0, 3) == 0) addr = $urandom;
            else                           addr = 32'($urandom_range(0, DW_WORDS - 1));
            do_req(rd, wr, addr, $urandom, $urandom_range(0, 6));
        end

        repeat (4) @(negedge clock);
        #1;
        check(0, "queue_drained", qf.size(), 32'd0);
        check(1, "queue_drained", qd.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
